// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encodings,
// the grant-index width helper and the fill-level safety margin.
package fifo_wr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Two spare words absorb the registered write and a stale fill level.
    localparam int ROOM_MARGIN = 2;

    function automatic int id_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 8; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin first-one finder: scans rr_last+1, rr_last+2, ...
// modulo NREQ and returns the first set request.
module rr_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_rr_last,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    int w_cand;

    // Scan farthest-first so the nearest candidate after rr_last wins.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        for (int off = NREQ; off >= 1; off--) begin
            w_cand = (int'(i_rr_last) + off) % NREQ;
            if (i_req[w_cand]) begin
                o_idx = ID_W'(w_cand);
                o_any = 1'b1;
            end else begin
                o_idx = o_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of an async FIFO write port.
// Optional FIFO_WR_ARB_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ         = 4,
    parameter  int DATA_WIDTH   = 16,
    parameter  int PTR_WIDTH    = 4,
    parameter  int BURST_LEN    = 8,
    parameter  int IDLE_TIMEOUT = 3,
    localparam int ID_W         = id_width(NREQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ-1:0]            i_req_last,
    input  logic [NREQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]            o_req_ready,
    output logic                       o_wr,
    output logic [DATA_WIDTH-1:0]      o_wdata,
    input  logic                       i_wfull,
    input  logic                       i_walmostfull,
    input  logic [PTR_WIDTH-1:0]       i_wfill,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    output logic [15:0]                o_stall_cnt,
`endif
    output logic                       o_busy,
    output logic [ID_W-1:0]            o_grant_id
);

    localparam int DEPTH      = 1 << PTR_WIDTH;
    localparam int ROOM_LIMIT = DEPTH - BURST_LEN - ROOM_MARGIN;
    localparam int BCNT_W     = $clog2(BURST_LEN + 1);
    localparam int ICNT_W     = $clog2(IDLE_TIMEOUT + 1);

    logic [0:0]            r_state;
    logic [ID_W-1:0]       r_grant_id;
    logic [ID_W-1:0]       r_rr_last;
    logic [BCNT_W-1:0]     r_beat_cnt;
    logic [ICNT_W-1:0]     r_idle_cnt;
    logic                  r_busy;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_room;
    logic                  w_any;
    logic [ID_W-1:0]       w_pick;
    logic                  w_valid_g;
    logic                  w_last_g;
    logic [DATA_WIDTH-1:0] w_data_g;
    logic                  w_xfer;
    logic                  w_exit;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .i_req     (i_req_valid),
        .i_rr_last (r_rr_last),
        .o_idx     (w_pick),
        .o_any     (w_any)
    );

    assign w_room    = !i_wfull && !i_walmostfull && (i_wfill <= PTR_WIDTH'(ROOM_LIMIT));
    assign w_valid_g = i_req_valid[r_grant_id];
    assign w_last_g  = i_req_last[r_grant_id];
    assign w_data_g  = i_req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_xfer    = (r_state == ST_BURST) && w_valid_g && !i_wfull && !i_rst;
    assign w_exit    = (w_xfer && (w_last_g || (r_beat_cnt == BCNT_W'(BURST_LEN - 1))))
                    || (!w_valid_g && (r_idle_cnt == ICNT_W'(IDLE_TIMEOUT - 1)));

    // Only the granted requester sees ready, and never while reset or FIFO full.
    always_comb begin
        o_req_ready = '0;
        if (!i_rst && (r_state == ST_BURST)) begin
            o_req_ready[r_grant_id] = !i_wfull;
        end else begin
            o_req_ready = '0;
        end
    end

    // Grant FSM with beat and idle counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
            r_rr_last  <= ID_W'(NREQ - 1);
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any && w_room) begin
                        r_state    <= ST_BURST;
                        r_busy     <= 1'b1;
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (w_exit) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_rr_last <= r_grant_id;
                    end else begin
                        r_state <= ST_BURST;
                        r_busy  <= 1'b1;
                    end
                    // A full-FIFO stall with valid held neither counts as a beat nor as idle.
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
                        r_idle_cnt <= '0;
                    end else if (!w_valid_g) begin
                        r_idle_cnt <= r_idle_cnt + ICNT_W'(1);
                    end else begin
                        r_idle_cnt <= r_idle_cnt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered FIFO write strobe and data, one cycle after acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_wr <= w_xfer;
            if (w_xfer) begin
                r_wdata <= w_data_g;
            end else begin
                r_wdata <= r_wdata;
            end
        end
    end

    assign o_wr       = r_wr;
    assign o_wdata    = r_wdata;
    assign o_busy     = r_busy;
    assign o_grant_id = r_grant_id;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where someone is waiting but nothing moves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= 16'h0000;
        end else if ((|i_req_valid) && !w_xfer && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed source streams, expected
// writes queued in hand-derived order, a negedge monitor checks every o_wr.
module tb_fifo_wr_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_req_valid;
    logic [3:0]  i_req_last;
    logic [63:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_wr;
    logic [15:0] o_wdata;
    logic        i_wfull;
    logic        i_walmostfull;
    logic [3:0]  i_wfill;
    logic        o_busy;
    logic [1:0]  o_grant_id;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    fifo_wr_arbiter dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .i_req_last    (i_req_last),
        .i_req_data    (i_req_data),
        .o_req_ready   (o_req_ready),
        .o_wr          (o_wr),
        .o_wdata       (o_wdata),
        .i_wfull       (i_wfull),
        .i_walmostfull (i_walmostfull),
        .i_wfill       (i_wfill),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        .o_stall_cnt   (o_stall_cnt),
`endif
        .o_busy        (o_busy),
        .o_grant_id    (o_grant_id)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [15:0] src_data [4][64];
    logic        src_last [4][64];
    int          src_len  [4];
    int          src_pos  [4];
    int          exp_idx  [4];
    logic [17:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          first_wr = -1;
    int          last_wr  = -1;

    function automatic logic [15:0] pat(input int k, input int j);
        return {4'hA, 4'(k), 8'(j)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic load(input int k, input int n, input int last_at);
        for (int j = 0; j < n; j++) begin
            src_data[k][src_len[k]] = pat(k, src_len[k]);
            src_last[k][src_len[k]] = ((j + 1) == last_at);
            src_len[k]++;
        end
    endtask

    task automatic exp_w(input int k, input int n);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back({2'(k), pat(k, exp_idx[k])});
            exp_idx[k]++;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (src_pos[k] < src_len[k]) begin
                i_req_valid[k]           = 1'b1;
                i_req_last[k]            = src_last[k][src_pos[k]];
                i_req_data[k*16 +: 16]   = src_data[k][src_pos[k]];
            end else begin
                i_req_valid[k]           = 1'b0;
                i_req_last[k]            = 1'b0;
                i_req_data[k*16 +: 16]   = 16'h0000;
            end
        end
    endtask

    task automatic step();
        logic [3:0] acc;
        drive();
        @(negedge i_clk);
        acc = i_req_valid & o_req_ready;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 4; k++) if (acc[k]) src_pos[k]++;
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += src_len[k] - src_pos[k];
        return s;
    endfunction

    task automatic wait_done(input string name, input int limit);
        int i;
        i = 0;
        while ((pending() > 0 || exp_q.size() > 0 || o_busy) && i < limit) begin
            step();
            i++;
        end
        check({name, "_bound"}, 32'(i < limit), 32'd1);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic busy_len(output int n);
        int w;
        w = 0;
        while (!o_busy && w < 20) begin step(); w++; end
        n = 0;
        while (o_busy && n < 50) begin step(); n++; end
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        drive();
        #1;
        check("rst_ready", 32'(o_req_ready), 32'd0);
        step();
        step();
        check("rst_wr", 32'(o_wr), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_grant", 32'(o_grant_id), 32'd0);
        check("rst_wdata", 32'(o_wdata), 32'd0);
        i_rst = 1'b0;
    endtask

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge i_clk) begin
        cyc++;
        if (o_wr === 1'b1) begin
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got id %0d data %h, required no write", o_grant_id, o_wdata);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({o_grant_id, o_wdata} === e) n_pass++;
                else $display("FAIL wr_data: got id %0d data %h, required id %0d data %h",
                              o_grant_id, o_wdata, e[17:16], e[15:0]);
            end
        end
    end

    initial begin
        int n;
        int base;
        int i;
        i_rst = 1'b1; i_req_valid = '0; i_req_last = '0; i_req_data = '0;
        i_wfull = 1'b0; i_walmostfull = 1'b0; i_wfill = 4'd0;
        for (int k = 0; k < 4; k++) begin src_len[k] = 0; src_pos[k] = 0; exp_idx[k] = 0; end
        apply_reset();

        // Single requester, full-length burst.
        load(1, 8, 0); exp_w(1, 8);
        busy_len(n);
        check("t1_burst_len", 32'(n), 32'd8);
        wait_done("t1", 100);
        check("t1_grant", 32'(o_grant_id), 32'd1);
        check("t1_wdata_last", 32'(o_wdata), 32'(pat(1, 7)));

        // Round robin from reset: 0,1,2,3,0 with one dead cycle between bursts.
        apply_reset();
        first_wr = -1;
        load(0, 16, 0); load(1, 8, 0); load(2, 8, 0); load(3, 8, 0);
        exp_w(0, 8); exp_w(1, 8); exp_w(2, 8); exp_w(3, 8); exp_w(0, 8);
        wait_done("t2", 200);
        check("t2_span", 32'(last_wr - first_wr), 32'd43);

        // Early last on requester 2's third beat; requester 3 goes next.
        load(2, 5, 3); load(3, 2, 2);
        exp_w(2, 3); exp_w(3, 2); exp_w(2, 2);
        busy_len(n);
        check("t3_burst_len", 32'(n), 32'd3);
        check("t3_grant", 32'(o_grant_id), 32'd2);
        wait_done("t3", 100);

        // Room gate: fill 7 blocks, fill 6 grants.
        i_wfill = 4'd7;
        load(1, 2, 2); exp_w(1, 2);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t4_gate_busy", 32'(o_busy), 32'd0);
            check("t4_gate_ready", 32'(o_req_ready), 32'd0);
        end
        i_wfill = 4'd6;
        step();
        check("t4_grant_busy", 32'(o_busy), 32'd1);
        check("t4_grant_id", 32'(o_grant_id), 32'd1);
        i_wfill = 4'd0;
        wait_done("t4", 50);

        // Idle timeout: two beats then silence releases the grant after three cycles.
        load(0, 2, 0); exp_w(0, 2);
        busy_len(n);
        check("t5_timeout_len", 32'(n), 32'd5);
        wait_done("t5", 50);

        // Full stall longer than the timeout must hold the burst.
        base = src_pos[1];
        load(1, 4, 4); exp_w(1, 4);
        i = 0;
        while (src_pos[1] < base + 1 && i < 30) begin step(); i++; end
        check("t5b_first_beat", 32'(src_pos[1] - base), 32'd1);
        i_wfull = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("t5b_stall_wr", 32'(o_wr), 32'd0);
            check("t5b_stall_ready", 32'(o_req_ready), 32'd0);
            check("t5b_stall_busy", 32'(o_busy), 32'd1);
        end
        i_wfull = 1'b0;
        wait_done("t5b", 50);

        // Reset on beat 4 abandons the burst; requester 0 wins first afterwards.
        base = src_pos[0];
        load(0, 8, 0); exp_w(0, 3);
        i = 0;
        while (src_pos[0] < base + 3 && i < 30) begin step(); i++; end
        check("t6_pre_beats", 32'(src_pos[0] - base), 32'd3);
        i_rst = 1'b1;
        drive();
        #1;
        check("t6_rst_ready", 32'(o_req_ready), 32'd0);
        step();
        check("t6_rst_wr", 32'(o_wr), 32'd0);
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        check("t6_rst_grant", 32'(o_grant_id), 32'd0);
        i_rst = 1'b0;
        load(1, 2, 2); load(3, 2, 2);
        exp_w(0, 5); exp_w(1, 2); exp_w(3, 2);
        wait_done("t6", 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
